// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-port arbiter for the 32x32 register file.
// The in-order pipe writeback has priority over the port. Long-latency results
// wait in a 2-entry FIFO. A scoreboard tracks registers that still have a
// long-latency result in flight and stalls issue on hazards against them.
// A starvation counter asks upstream for a bubble when the FIFO is blocked too long.
module regfile_wb_sched #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        pipe_we_i,
   input  logic [4:0]  pipe_waddr_i,
   input  logic [31:0] pipe_wdata_i,
   input  logic        lu_valid_i,
   output logic        lu_ready_o,
   input  logic [4:0]  lu_waddr_i,
   input  logic [31:0] lu_wdata_i,
   input  logic        iss_valid_i,
   input  logic [4:0]  iss_waddr_i,
   input  logic [4:0]  iss_rs1_i,
   input  logic [4:0]  iss_rs2_i,
   input  logic [4:0]  iss_rd_i,
   output logic        iss_stall_o,
   output logic        drain_req_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o
);

   logic             pipe_eff;
   logic             fifo_ne;
   logic             pop;
   logic             push;
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0][4:0]  addr_q;
   logic [1:0][31:0] data_q;
   logic [31:0]      busy_q, busy_d;
   logic [3:0]       starve_q, starve_d;
   logic             drain_q, drain_d;

   // Writes to x0 are dropped entirely, so they never claim the port.
   assign pipe_eff    = pipe_we_i & (pipe_waddr_i != 5'd0);
   assign fifo_ne     = (count_q != 2'd0);
   assign pop         = fifo_ne & ~pipe_eff;
   // Ready comes only from the registered count; a pop does not free a full FIFO this cycle.
   assign lu_ready_o  = (count_q != 2'd2);
   assign push        = lu_valid_i & lu_ready_o & (lu_waddr_i != 5'd0);
   assign iss_stall_o = busy_q[iss_rs1_i] | busy_q[iss_rs2_i] | busy_q[iss_rd_i];
   assign drain_req_o = drain_q;

   // Port mux: pipe first, then FIFO head; write enable held off during reset.
   always_comb begin
      rf_we_o    = rstn & (pipe_eff | fifo_ne);
      rf_waddr_o = pipe_eff ? pipe_waddr_i : addr_q[rd_ptr_q];
      rf_wdata_o = pipe_eff ? pipe_wdata_i : data_q[rd_ptr_q];
   end

   // Next occupancy, busy bits and starvation tracking.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      busy_d = busy_q;
      if (pop)
         busy_d[addr_q[rd_ptr_q]] = 1'b0;
      // A new issue to the same register outranks the clear from the pop.
      if (iss_valid_i && (iss_waddr_i != 5'd0))
         busy_d[iss_waddr_i] = 1'b1;
      busy_d[0] = 1'b0;

      starve_d = starve_q;
      drain_d  = drain_q;
      if (!fifo_ne || pop) begin
         starve_d = 4'd0;
         drain_d  = 1'b0;
      end else begin
         // Here the FIFO is non-empty and the pipe holds the port.
         if (starve_q >= 4'(STARVE_MAX - 1))
            drain_d = 1'b1;
         if (starve_q < 4'(STARVE_MAX))
            starve_d = starve_q + 4'd1;
      end
   end

   // State registers; reset discards queued results and busy bits.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         busy_q   <= '0;
         starve_q <= 4'd0;
         drain_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         busy_q   <= busy_d;
         starve_q <= starve_d;
         drain_q  <= drain_d;
         if (push) begin
            addr_q[wr_ptr_q] <= lu_waddr_i;
            data_q[wr_ptr_q] <= lu_wdata_i;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
      end
   end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and busy-register scoreboard in front of the 32x32 register file. The file has a single write port, and two sources compete for it. The in-order pipeline writeback has no backpressure and always wins. The long-latency unit (mul/div/load-miss) is handshaked and buffered in a 2-entry FIFO. The block also tracks registers with an outstanding long-latency result and raises an issue stall on RAW/WAW hazards against them.

## Interface
- STARVE_MAX, 4: consecutive blocked cycles of a non-empty FIFO before a drain slot is requested (1..15).
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- pipe_we  in  1  pipeline writeback enable
- pipe_waddr  in  5  pipeline writeback register
- pipe_wdata  in  32  pipeline writeback data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  result accepted this cycle when lu_valid&lu_ready
- lu_waddr  in  5  long-latency destination
- lu_wdata  in  32  long-latency data
- iss_valid  in  1  a long-latency op issues this cycle (marks iss_waddr busy)
- iss_waddr  in  5  destination of issuing long-latency op
- iss_rs1, iss_rs2, iss_rd  in  5 each  operands/destination of instruction in issue
- iss_stall  out  1  hazard against a busy register
- drain_req  out  1  upstream must insert a bubble (pipe_we=0) next cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data

## Operation
- Pipe write effective = pipe_we & (pipe_waddr!=0). Writes to x0 never reach rf_we and never occupy the port.
- Port mux (combinational): effective pipe write -> rf_* = pipe_*. Otherwise, FIFO non-empty -> rf_* = head, pop. Otherwise rf_we=0; rf_waddr and rf_wdata hold don't-care values.
- FIFO: 2 entries, registered count 0..2, wrap-around rd/wr pointers. lu_ready = (count<2), registered-state only, with no pass-through when full. An accepted result with lu_waddr==0 is discarded and not pushed. Simultaneous push and pop is allowed at count 1. At count 2, a pop frees the slot, but lu_ready stays low that cycle.
- Scoreboard busy[31:1] (bit 0 constant 0):
  - set on iss_valid & iss_waddr!=0;
  - cleared when a FIFO pop writes that address.
  - Same-cycle set and clear of the same bit: set wins.
- iss_stall = busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd], combinational. Upstream never asserts iss_valid to a busy iss_waddr; doing so is a protocol error, and the bit simply stays set.
- Starvation counter (4-bit): increments each cycle count>0 and the port is taken by pipe. Resets to 0 on any pop or when count==0. drain_req is registered, set when counter reaches STARVE_MAX-1 while blocking, and cleared on the cycle after the pop. If the upstream ignores drain_req, pipe still wins and the counter saturates at STARVE_MAX.

## Timing
- Reset values (async): count 0, pointers 0, busy all 0, counter 0, drain_req 0, lu_ready 1 after deassert. rf_we forced 0 while rstn low.
- Reset mid-operation discards FIFO contents and busy bits; no write completes.
- rf_* are combinational; the write lands on the same clk edge as the pipe/pop decision.
- Minimum FIFO latency: result accepted at edge N appears on rf_* in cycle N+1, written at edge N+1 if pipe idle.
- Busy bit visible to iss_stall the cycle after iss_valid. It clears the cycle after the writing pop, so the consumer can issue the cycle after the register-file write.
- Throughput: one lu result per cycle while pipe idle.

## Test plan
- Reset then idle: lu_ready=1, iss_stall=0, rf_we=0, drain_req=0.
- Conflict: pipe writes r5=0x11 and lu_valid r6=0x22 in the same cycle. rf writes r5 first and r6 the next cycle; lu_ready stays 1.
- Scoreboard: iss_valid r7 -> busy. iss_rs1=7 stalls until the lu result r7=0xABCD is popped, then stall drops the next cycle.
- Full FIFO: pipe_we=1 continuously, 3 lu results. Two are accepted, then lu_ready=0. After STARVE_MAX (default 4) blocked cycles, drain_req=1; the bubble pops the head.
- x0 handling: pipe_waddr=0 with pipe_we=1 lets the FIFO head drain. lu_waddr=0 is accepted and discarded with no rf_we.
- Async reset with 2 entries queued and busy[9] set: everything clears immediately, and no write of the queued data occurs after release.
